// File: rtl/sync_down_counter.sv
// sync_down_counter
//   Synchronous, loadable n-bit down counter with terminal-count detection
//   and optional auto-reload. It serves as a programmable interval timer or
//   tick generator. A load starts a countdown. While enabled, the counter
//   decrements once per edge. Reaching terminal count raises a one-cycle
//   done pulse, then the counter either stops at 0 or reloads the stored value.
//
// Ports
//   clk         : single clock; all state updates on the rising edge
//   reset       : asynchronous active-high reset (Q=0, IDLE, done=0)
//   load        : synchronous load strobe; has priority over everything else
//   load_val    : value captured into Q and the reload register on load
//   en          : count enable; low freezes Q and state
//   auto_reload : at terminal count, reload instead of stopping
//   Q           : current count (registered)
//   busy        : high while counting (decode of the state register)
//   done        : one-cycle pulse on terminal count (registered)
module sync_down_counter #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] load_val,
    input  logic         en,
    input  logic         auto_reload,
    output logic [n-1:0] Q,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};
    localparam logic [n-1:0] ZERO = '0;

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] reload_reg;
    logic [n-1:0] reload_nxt;
    logic [n-1:0] q_nxt;
    logic         done_nxt;

    // State, count and done register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            Q          <= ZERO;
            reload_reg <= ZERO;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            Q          <= q_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_nxt  = state;
        q_nxt      = Q;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;

        if (load) begin
            // A load of zero has nothing to count, so it parks in IDLE
            // and never produces a done pulse.
            q_nxt      = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != ZERO) ? COUNT : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    // Q holds; en is ignored so there is no wrap from 0.
                end
                COUNT: begin
                    if (en) begin
                        if (Q == ONE) begin
                            // Terminal count: auto_reload is only looked at here.
                            done_nxt = 1'b1;
                            if (auto_reload) begin
                                q_nxt = reload_reg;
                            end else begin
                                q_nxt     = ZERO;
                                state_nxt = IDLE;
                            end
                        end else if (Q == ZERO) begin
                            // Unreachable in normal operation; fall back to IDLE
                            // rather than underflowing.
                            state_nxt = IDLE;
                        end else begin
                            q_nxt = Q - ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         load;
    logic [N-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [N-1:0] Q;
    logic         busy;
    logic         done;

    int errors;
    int checks;

    sync_down_counter #(.n(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .Q           (Q),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int q_exp, input int busy_exp,
                             input int done_exp);
        check({tag, ".Q"},    int'(Q),    q_exp);
        check({tag, ".busy"}, int'(busy), busy_exp);
        check({tag, ".done"}, int'(done), done_exp);
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        en          = 1'b0;
        auto_reload = 1'b0;

        // Power-up reset, observed between edges
        #1 reset = 1'b1;
        #1 check_out("reset_init", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Load 5, then assert reset between edges: must clear without an edge
        load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0;
        check_out("pre_reset_load5", 5, 1, 0);
        #2 reset = 1'b1;
        #1 check_out("async_reset", 0, 0, 0);
        #1 reset = 1'b0;
        en = 1'b1;
        tick();
        check_out("after_reset_en", 0, 0, 0);
        tick();
        check_out("after_reset_en2", 0, 0, 0);

        // One-shot: load 5
        load = 1'b1; load_val = 4'd5; auto_reload = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        check_out("oneshot_load", 5, 1, 0);
        for (int k = 4; k >= 1; k--) begin
            tick();
            check_out("oneshot_count", k, 1, 0);
        end
        tick();
        check_out("oneshot_done", 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out("oneshot_hold", 0, 0, 0);
        end

        // Auto-reload: load 3 -> 3,2,1,3,2,1,3 with done on each reload
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        check_out("auto_load", 3, 1, 0);
        for (int r = 0; r < 2; r++) begin
            tick(); check_out("auto_q2", 2, 1, 0);
            tick(); check_out("auto_q1", 1, 1, 0);
            tick(); check_out("auto_reload", 3, 1, 1);
        end

        // Pause: load 4, enable pattern 1,0,0,1,1,1
        auto_reload = 1'b0;
        load = 1'b1; load_val = 4'd4; en = 1'b1;
        tick();
        load = 1'b0;
        check_out("pause_load", 4, 1, 0);
        en = 1'b1; tick(); check_out("pause_e1", 3, 1, 0);
        en = 1'b0; tick(); check_out("pause_e0a", 3, 1, 0);
        en = 1'b0; tick(); check_out("pause_e0b", 3, 1, 0);
        en = 1'b1; tick(); check_out("pause_e1b", 2, 1, 0);
        en = 1'b1; tick(); check_out("pause_e1c", 1, 1, 0);
        en = 1'b1; tick(); check_out("pause_done", 0, 0, 1);

        // Load collision at terminal count
        load = 1'b1; load_val = 4'd2; en = 1'b1;
        tick();
        load = 1'b0;
        check_out("coll_load2", 2, 1, 0);
        tick();
        check_out("coll_q1", 1, 1, 0);
        load = 1'b1; load_val = 4'd9;
        tick();
        check_out("coll_load9", 9, 1, 0);
        load_val = 4'd0;
        tick();
        load = 1'b0;
        check_out("coll_load0", 0, 0, 0);
        tick();
        check_out("coll_idle", 0, 0, 0);

        // All-ones load: exactly 15 enabled edges to done
        load = 1'b1; load_val = 4'd15; en = 1'b1;
        tick();
        load = 1'b0;
        check_out("max_load", 15, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_out("max_count", 15 - k, (k == 15) ? 0 : 1, (k == 15) ? 1 : 0);
        end

        // Load 1 with auto-reload: done held high, Q stays 1
        load = 1'b1; load_val = 4'd1; auto_reload = 1'b1; en = 1'b1;
        tick();
        load = 1'b0;
        check_out("one_load", 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("one_auto", 1, 1, 1);
        end
        auto_reload = 1'b0;
        tick();
        check_out("one_last", 0, 0, 1);
        tick();
        check_out("one_after", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous, loadable N-bit down counter with terminal-count detection and optional auto-reload.
- Complements the team's ripple up counter. Every flip-flop shares one clock, so there is no ripple delay on Q; all outputs are valid one clk-to-Q after the edge.
- Used as a programmable interval timer and tick generator. Software or an FSM loads a count, the block decrements while enabled, then signals expiry with a one-cycle done pulse.

Parameters:
- n, 4, counter width in bits (n >= 2).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- load, input, 1, synchronous load strobe.
- load_val, input, n, value captured on load.
- en, input, 1, count enable; low freezes Q and state.
- auto_reload, input, 1, at terminal count, reload from the stored value instead of stopping.
- Q, output, n, current count (registered).
- busy, output, 1, high while state is COUNT (registered state decode).
- done, output, 1, one-cycle pulse on terminal count (registered).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port named reset.
- Reset asserted, independent of clk: Q=0, reload_reg=0, state=IDLE, busy=0, done=0. Outputs hold these values until the first clk edge after reset deasserts.
- Internal register reload_reg[n-1:0] holds the last loaded value.
- States: IDLE, COUNT. busy = (state==COUNT).
- Load priority (any state): load=1 at edge -> Q<=load_val, reload_reg<=load_val, done<=0. Next state is COUNT if load_val!=0, otherwise IDLE. load overrides en and terminal count in the same cycle, so no done pulse is produced.
- IDLE:
  - Q holds.
  - en has no effect; no wrap from 0 to 2^n-1.
  - done<=0.
- COUNT with en=0: Q, state and reload_reg hold; done<=0.
- COUNT with en=1, Q>1: Q<=Q-1, done<=0.
- COUNT with en=1, Q==1 (terminal count): done<=1. auto_reload is sampled at this edge only.
  - auto_reload=0: Q<=0, state<=IDLE.
  - auto_reload=1: Q<=reload_reg, state stays COUNT.
- Timing consequences:
  - With en held high, done asserts exactly load_val edges after the load edge.
  - In auto-reload mode, done has period load_val cycles. For load_val=1 this means done is high continuously and Q stays at 1.
- done is high for exactly one cycle per terminal count. It is never asserted in the same cycle as reset or load.
- Max load_val = 2^n-1 (all ones). Arithmetic is unsigned; Q never underflows.
- Reset mid-count aborts immediately: Q=0, IDLE, done=0, reload_reg=0. A subsequent auto-reload therefore requires a new load.
- auto_reload changes while counting have no effect until the terminal-count edge.
- en toggling mid-count pauses exactly; total enabled cycles to done = load_val.

Test Plan:
- Reset: assert reset at t=2ns between edges with Q=5 -> Q=0, busy=0, done=0 immediately, not waiting for an edge. Release, pulse en -> Q stays 0.
- One-shot: n=4, load 5, en=1, auto_reload=0 -> Q=5,4,3,2,1,0 on successive edges. done high only in the cycle Q first equals 0. busy falls in the same cycle. Q then holds 0 for 10 further cycles.
- Auto-reload: load 3, auto_reload=1, en=1 -> Q sequence 3,2,1,3,2,1,... and done high every 3rd cycle, coincident with Q=3. busy stays 1.
- Pause: load 4, en pattern 1,0,0,1,1,1 -> Q=4,3,3,3,2,1,0. done fires after the 4th enabled edge.
- Load collision: during COUNT with Q=1, en=1, assert load with load_val=9 -> Q=9, done=0, busy=1. Then load load_val=0 -> Q=0, IDLE, no done.
- Boundaries: load 15 (all ones), run to done -> exactly 15 enabled edges. load 1 with auto_reload=1 -> done constantly high, Q=1. Drop auto_reload -> the next edge gives Q=0, IDLE, done high for one last cycle, then 0.
